// File: rtl/model_bb_step_sequencer.sv
// Step/PWM/coefficient sequencer for the buck-boost L2 plant model.
// Ports: aclk, resetn (sync, active-low); run/step_req control; ce_div,
//   pwm_period, pwm_duty settings; cfg_valid/cfg_ready + cfg_* coefficient
//   offer; k*/vdc active coefficients; ce, s1, period_start, step_count, state.
module model_bb_step_sequencer #(
    parameter int MODEL_DATA_WIDTH = 32,
    parameter int PWM_WIDTH        = 16,
    parameter int DIV_WIDTH        = 16
) (
    input  logic                        aclk,
    input  logic                        resetn,
    input  logic                        run,
    input  logic                        step_req,
    input  logic [DIV_WIDTH-1:0]        ce_div,
    input  logic [PWM_WIDTH-1:0]        pwm_period,
    input  logic [PWM_WIDTH-1:0]        pwm_duty,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    input  logic [MODEL_DATA_WIDTH-1:0] cfg_kL,
    input  logic [MODEL_DATA_WIDTH-1:0] cfg_kC,
    input  logic [MODEL_DATA_WIDTH-1:0] cfg_kR,
    input  logic [MODEL_DATA_WIDTH-1:0] cfg_kRL,
    input  logic [MODEL_DATA_WIDTH-1:0] cfg_kRC,
    input  logic [MODEL_DATA_WIDTH-1:0] cfg_vdc,
    output logic [MODEL_DATA_WIDTH-1:0] kL,
    output logic [MODEL_DATA_WIDTH-1:0] kC,
    output logic [MODEL_DATA_WIDTH-1:0] kR,
    output logic [MODEL_DATA_WIDTH-1:0] kRL,
    output logic [MODEL_DATA_WIDTH-1:0] kRC,
    output logic [MODEL_DATA_WIDTH-1:0] vdc,
    output logic                        ce,
    output logic                        s1,
    output logic                        period_start,
    output logic [31:0]                 step_count,
    output logic [1:0]                  state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_STEP = 2'b10
    } state_t;

    localparam int NK = 6;
    localparam int KW = NK * MODEL_DATA_WIDTH;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_ce;
    logic                   w_ce_nxt;
    logic [DIV_WIDTH-1:0]   r_div_cnt;
    logic [DIV_WIDTH-1:0]   w_div_nxt;
    logic [PWM_WIDTH-1:0]   r_car_cnt;
    logic [PWM_WIDTH-1:0]   r_period_sh;
    logic [PWM_WIDTH-1:0]   r_duty_sh;
    logic                   r_s1;
    logic                   r_period_start;
    logic [31:0]            r_step_count;
    logic                   r_pend_full;
    logic [KW-1:0]          r_pend;
    logic [KW-1:0]          r_k;

    logic [PWM_WIDTH:0]     w_car_inc;
    logic                   w_wrap;
    logic [PWM_WIDTH-1:0]   w_car_nxt;
    logic [PWM_WIDTH-1:0]   w_period_ld;
    logic                   w_s1_nxt;
    logic                   w_commit;
    logic                   w_capture;

    always_comb begin
        w_state_nxt = r_state;
        w_ce_nxt    = 1'b0;
        w_div_nxt   = r_div_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (run) begin
                    w_state_nxt = S_RUN;
                end else if (step_req) begin
                    w_state_nxt = S_STEP;
                    w_ce_nxt    = 1'b1;
                end
            end
            S_RUN: begin
                if (!run) begin
                    w_state_nxt = S_IDLE;
                    w_div_nxt   = '0;
                end else if (r_div_cnt >= ce_div) begin
                    // >= so a shrinking ce_div cannot strand the count
                    w_ce_nxt  = 1'b1;
                    w_div_nxt = '0;
                end else begin
                    w_div_nxt = r_div_cnt + DIV_WIDTH'(1);
                end
            end
            S_STEP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // One extra bit keeps car_cnt+1 from wrapping at the top of the range
    assign w_car_inc   = {1'b0, r_car_cnt} + (PWM_WIDTH+1)'(1);
    assign w_wrap      = (w_car_inc >= {1'b0, r_period_sh});
    assign w_car_nxt   = w_wrap ? '0 : w_car_inc[PWM_WIDTH-1:0];
    assign w_period_ld = (pwm_period == '0) ? PWM_WIDTH'(1) : pwm_period;
    // On a wrap the freshly loaded duty governs step 0 (0 < duty)
    assign w_s1_nxt    = w_wrap ? (pwm_duty != '0)
                                : (w_car_nxt < r_duty_sh);

    // Capture needs an empty buffer, commit a full one: never the same edge
    assign w_commit  = r_pend_full &&
                       ((r_ce && w_wrap) || (r_state == S_IDLE));
    assign w_capture = cfg_valid && !r_pend_full;

    always_ff @(posedge aclk) begin
        if (!resetn) begin
            r_state        <= S_IDLE;
            r_ce           <= 1'b0;
            r_div_cnt      <= '0;
            r_car_cnt      <= '0;
            r_period_sh    <= PWM_WIDTH'(1);
            r_duty_sh      <= '0;
            r_s1           <= 1'b0;
            r_period_start <= 1'b0;
            r_step_count   <= '0;
            r_pend_full    <= 1'b0;
            r_pend         <= '0;
            r_k            <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_ce           <= w_ce_nxt;
            r_div_cnt      <= w_div_nxt;
            r_period_start <= 1'b0;
            if (r_ce) begin
                r_car_cnt    <= w_car_nxt;
                r_s1         <= w_s1_nxt;
                r_step_count <= r_step_count + 32'd1;
                if (w_wrap) begin
                    r_period_sh    <= w_period_ld;
                    r_duty_sh      <= pwm_duty;
                    r_period_start <= 1'b1;
                end
            end
            if (w_commit) begin
                r_k         <= r_pend;
                r_pend_full <= 1'b0;
            end else if (w_capture) begin
                r_pend      <= {cfg_kL, cfg_kC, cfg_kR,
                                cfg_kRL, cfg_kRC, cfg_vdc};
                r_pend_full <= 1'b1;
            end
        end
    end

    assign cfg_ready    = !r_pend_full;
    assign {kL, kC, kR, kRL, kRC, vdc} = r_k;
    assign ce           = r_ce;
    assign s1           = r_s1;
    assign period_start = r_period_start;
    assign step_count   = r_step_count;
    assign state        = r_state;

endmodule

// File: tb/tb_model_bb_step_sequencer.sv
// Scoreboard bench for model_bb_step_sequencer: directed stimulus pushes
// the expected per-step results; a negedge monitor pops on every ce.
module tb_model_bb_step_sequencer;

    localparam int MW = 32;
    localparam int PW = 16;
    localparam int DW = 16;

    logic          aclk = 1'b0;
    logic          resetn;
    logic          run;
    logic          step_req;
    logic [DW-1:0] ce_div;
    logic [PW-1:0] pwm_period;
    logic [PW-1:0] pwm_duty;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [MW-1:0] cfg_kL, cfg_kC, cfg_kR, cfg_kRL, cfg_kRC, cfg_vdc;
    logic [MW-1:0] kL, kC, kR, kRL, kRC, vdc;
    logic          ce;
    logic          s1;
    logic          period_start;
    logic [31:0]   step_count;
    logic [1:0]    state;

    model_bb_step_sequencer #(
        .MODEL_DATA_WIDTH(MW),
        .PWM_WIDTH(PW),
        .DIV_WIDTH(DW)
    ) dut (
        .aclk(aclk), .resetn(resetn), .run(run), .step_req(step_req),
        .ce_div(ce_div), .pwm_period(pwm_period), .pwm_duty(pwm_duty),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_kL(cfg_kL), .cfg_kC(cfg_kC), .cfg_kR(cfg_kR),
        .cfg_kRL(cfg_kRL), .cfg_kRC(cfg_kRC), .cfg_vdc(cfg_vdc),
        .kL(kL), .kC(kC), .kR(kR), .kRL(kRL), .kRC(kRC), .vdc(vdc),
        .ce(ce), .s1(s1), .period_start(period_start),
        .step_count(step_count), .state(state)
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          cyc;
        logic        s1;
        logic        ps;
        logic [31:0] cnt;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string nm, input logic [191:0] act,
                       input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic push(input int c, input logic e_s1, input logic e_ps,
                        input int e_cnt);
        exp_t e;
        e.cyc = c;
        e.s1  = e_s1;
        e.ps  = e_ps;
        e.cnt = 32'(e_cnt);
        q.push_back(e);
    endtask

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [191:0] kvec;
        return {kL, kC, kR, kRL, kRC, vdc};
    endfunction

    task automatic offer(input logic [MW-1:0] base);
        cfg_kL    = base;
        cfg_kC    = base + 32'h11;
        cfg_kR    = base + 32'h22;
        cfg_kRL   = base + 32'h33;
        cfg_kRC   = base + 32'h44;
        cfg_vdc   = base + 32'h55;
        cfg_valid = 1'b1;
    endtask

    function automatic logic [191:0] kset(input logic [MW-1:0] base);
        return {base, base + 32'h11, base + 32'h22,
                base + 32'h33, base + 32'h44, base + 32'h55};
    endfunction

    // Monitor: a ce seen on one negedge is checked against the popped
    // entry, and the post-step outputs are checked on the next negedge.
    exp_t m_exp;
    logic m_pend = 1'b0;
    always @(negedge aclk) begin
        if (m_pend) begin
            chk("step_s1", 192'(s1), 192'(m_exp.s1));
            chk("step_period_start", 192'(period_start), 192'(m_exp.ps));
            chk("step_count", 192'(step_count), 192'(m_exp.cnt));
            m_pend = 1'b0;
        end
        if (ce === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ce: ce=1 at cycle %0d, required 0",
                         cyc);
            end else begin
                m_exp = q.pop_front();
                chk("ce_cycle", 192'(cyc), 192'(m_exp.cyc));
                m_pend = 1'b1;
            end
        end
    end

    localparam logic [MW-1:0] K1 = 32'h0100_0000;
    localparam logic [MW-1:0] K2 = 32'hA000_0001;
    localparam logic [MW-1:0] K3 = 32'h5000_0000;

    initial begin
        int e;
        int c;
        int d;
        int kk;
        logic xs1;
        resetn     = 1'b0;
        run        = 1'b0;
        step_req   = 1'b0;
        ce_div     = '0;
        pwm_period = 16'd10;
        pwm_duty   = 16'd3;
        cfg_valid  = 1'b0;
        cfg_kL = '0; cfg_kC = '0; cfg_kR = '0;
        cfg_kRL = '0; cfg_kRC = '0; cfg_vdc = '0;
        repeat (3) tick;
        resetn = 1'b1;
        tick;

        chk("rst_state", 192'(state), 192'(0));
        chk("rst_ce", 192'(ce), 192'(0));
        chk("rst_s1", 192'(s1), 192'(0));
        chk("rst_period_start", 192'(period_start), 192'(0));
        chk("rst_step_count", 192'(step_count), 192'(0));
        chk("rst_cfg_ready", 192'(cfg_ready), 192'(1));
        chk("rst_k", kvec(), 192'(0));

        // Divider: ce_div=3 -> ce 4, 8, 12 cycles after the entry edge
        ce_div = 16'd3;
        run    = 1'b1;
        e      = cyc + 1;
        push(e + 4, 1'b1, 1'b1, 1);
        push(e + 8, 1'b1, 1'b0, 2);
        push(e + 12, 1'b1, 1'b0, 3);
        while (cyc < e + 12) tick;
        chk("run_state", 192'(state), 192'(1));
        run = 1'b0;
        tick;
        chk("stop_state", 192'(state), 192'(0));
        chk("stop_step_count", 192'(step_count), 192'(3));

        // PWM: period 10, duty 3 -> 0 -> 12, ce every cycle
        resetn = 1'b0;
        tick;
        resetn = 1'b1;
        tick;
        ce_div   = '0;
        pwm_duty = 16'd3;
        run      = 1'b1;
        e        = cyc + 1;
        for (int k = 0; k < 40; k++) begin
            d   = (k < 20) ? 3 : ((k < 30) ? 0 : 12);
            kk  = k % 10;
            xs1 = (kk < d);
            push(e + 1 + k, xs1, kk == 0, k + 1);
        end
        while (cyc < e + 40) begin
            tick;
            if (cyc == e + 15) pwm_duty = 16'd0;
            if (cyc == e + 25) pwm_duty = 16'd12;
        end
        run = 1'b0;
        tick;

        // Coefficient commit in RUN waits for the period boundary
        pwm_duty = 16'd3;
        run      = 1'b1;
        e        = cyc + 1;
        for (int k = 0; k < 15; k++)
            push(e + 1 + k, (k % 10) < 3, (k % 10) == 0, 41 + k);
        while (cyc < e + 15) begin
            tick;
            if (cyc == e + 3) offer(K1);
            if (cyc == e + 4) begin
                cfg_valid = 1'b0;
                chk("run_cap_ready", 192'(cfg_ready), 192'(0));
                chk("run_cap_k_hold", kvec(), 192'(0));
            end
            if (cyc == e + 11) begin
                chk("run_prewrap_k", kvec(), 192'(0));
                chk("run_prewrap_ready", 192'(cfg_ready), 192'(0));
            end
            if (cyc == e + 12) begin
                chk("run_commit_ps", 192'(period_start), 192'(1));
                chk("run_commit_k", kvec(), kset(K1));
                chk("run_commit_ready", 192'(cfg_ready), 192'(1));
            end
        end
        run = 1'b0;
        tick;
        tick;

        // Coefficient commit in IDLE one cycle after capture
        offer(K2);
        tick;
        cfg_valid = 1'b0;
        chk("idle_cap_ready", 192'(cfg_ready), 192'(0));
        chk("idle_cap_k_hold", kvec(), kset(K1));
        tick;
        chk("idle_commit_k", kvec(), kset(K2));
        chk("idle_commit_ready", 192'(cfg_ready), 192'(1));
        chk("idle_commit_state", 192'(state), 192'(0));

        // Single steps while stopped; carrier 4 -> 5, 6, 7
        for (int i = 0; i < 3; i++) begin
            step_req = 1'b1;
            c = cyc;
            push(c + 1, 1'b0, 1'b0, 56 + i);
            tick;
            step_req = 1'b0;
            chk("step_state", 192'(state), 192'(2));
            tick;
            chk("step_back_idle", 192'(state), 192'(0));
            repeat (3) tick;
        end

        // step_req inside RUN must not add a ce
        ce_div = 16'd7;
        run    = 1'b1;
        e      = cyc + 1;
        push(e + 8, 1'b0, 1'b0, 59);
        while (cyc < e + 8) begin
            tick;
            if (cyc == e + 2) step_req = 1'b1;
            if (cyc == e + 3) begin
                step_req = 1'b0;
                chk("run_ignores_step", 192'(state), 192'(1));
            end
        end
        run = 1'b0;
        tick;
        tick;

        // Reset mid-RUN with a set pending
        ce_div = 16'd15;
        run    = 1'b1;
        e      = cyc + 1;
        while (cyc < e + 5) begin
            tick;
            if (cyc == e + 2) offer(K3);
            if (cyc == e + 3) begin
                cfg_valid = 1'b0;
                chk("pre_rst_ready", 192'(cfg_ready), 192'(0));
            end
        end
        resetn = 1'b0;
        tick;
        chk("mid_rst_ce", 192'(ce), 192'(0));
        chk("mid_rst_s1", 192'(s1), 192'(0));
        chk("mid_rst_k", kvec(), 192'(0));
        chk("mid_rst_ready", 192'(cfg_ready), 192'(1));
        chk("mid_rst_count", 192'(step_count), 192'(0));
        chk("mid_rst_state", 192'(state), 192'(0));
        resetn = 1'b1;
        run    = 1'b0;
        repeat (4) tick;

        chk("missing_ce", 192'(q.size()), 192'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
